// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Write-back arbiter that shares the two register-file write ports between LSU, EX and buffered APU results.
// LSU always wins a port, and EX and APU share the other port under round-robin. All write outputs are registered.
module cv32e40p_rf_wb_arbiter #(
  parameter  int ADDR_WIDTH     = 6,
  parameter  int DATA_WIDTH     = 32,
  parameter  int APU_FIFO_DEPTH = 2,
  localparam int PTR_W          = (APU_FIFO_DEPTH > 1) ? $clog2(APU_FIFO_DEPTH) : 1,
  localparam int CNT_W          = $clog2(APU_FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,

  input  logic                  ex_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_data_i,
  output logic                  ex_ready_o,

  input  logic                  apu_valid_i,
  input  logic [ADDR_WIDTH-1:0] apu_addr_i,
  input  logic [DATA_WIDTH-1:0] apu_data_i,
  output logic                  apu_ready_o,

  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic                  superseded_o,
  output logic [CNT_W-1:0]      apu_fifo_cnt_o
);

  // ---------------------------------------------------------------------------
  // APU result FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] fifo_addr [APU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [APU_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  push, pop, fifo_valid;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign apu_ready_o    = (cnt_q != CNT_W'(APU_FIFO_DEPTH));
  assign fifo_valid     = (cnt_q != '0);
  assign push           = apu_valid_i && apu_ready_o;
  assign head_addr      = fifo_addr[rd_ptr_q];
  assign head_data      = fifo_data[rd_ptr_q];
  assign apu_fifo_cnt_o = cnt_q;

  // NOTE: payload storage has no reset; occupancy is tracked by cnt_q, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= apu_addr_i;
      fifo_data[wr_ptr_q] <= apu_data_i;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Grant: LSU always; EX/APU both unless all three contend, then round-robin
  // ---------------------------------------------------------------------------
  logic rr_q;
  logic three_way, grant_ex, grant_apu;

  assign three_way = lsu_valid_i && ex_valid_i && fifo_valid;

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    grant_ex  = ex_valid_i;
    grant_apu = fifo_valid;
    if (three_way) begin
      grant_ex  = !rr_q;
      grant_apu = rr_q;
    end
  end

  assign ex_ready_o = grant_ex;
  assign pop        = grant_apu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rr_q <= 1'b0;
    else if (three_way) rr_q <= grant_ex;
  end

  // ---------------------------------------------------------------------------
  // Port routing, x0 filter and same-address collision resolution
  // ---------------------------------------------------------------------------
  logic                  a_vld, b_vld, collision, we_a_d, we_b_d;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] a_data, b_data;

  always_comb begin
    a_vld  = 1'b0;
    a_addr = '0;
    a_data = '0;
    b_vld  = 1'b0;
    b_addr = '0;
    b_data = '0;
    if (lsu_valid_i) begin
      a_vld  = 1'b1;
      a_addr = lsu_addr_i;
      a_data = lsu_data_i;
      if (grant_ex) begin
        b_vld  = 1'b1;
        b_addr = ex_addr_i;
        b_data = ex_data_i;
      end else if (grant_apu) begin
        b_vld  = 1'b1;
        b_addr = head_addr;
        b_data = head_data;
      end
    end else begin
      if (grant_apu) begin
        a_vld  = 1'b1;
        a_addr = head_addr;
        a_data = head_data;
      end
      if (grant_ex) begin
        b_vld  = 1'b1;
        b_addr = ex_addr_i;
        b_data = ex_data_i;
      end
    end

    collision = a_vld && b_vld && (a_addr == b_addr) && (a_addr != '0);
    // EX > LSU > APU: only the LSU-vs-APU pairing needs the winner moved onto port B.
    if (collision && lsu_valid_i && grant_apu) begin
      b_addr = lsu_addr_i;
      b_data = lsu_data_i;
    end

    we_a_d = a_vld && (a_addr != '0) && !collision;
    we_b_d = b_vld && (b_addr != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a_o       <= 1'b0;
      waddr_a_o    <= '0;
      wdata_a_o    <= '0;
      we_b_o       <= 1'b0;
      waddr_b_o    <= '0;
      wdata_b_o    <= '0;
      superseded_o <= 1'b0;
    end else begin
      we_a_o       <= we_a_d;
      waddr_a_o    <= we_a_d ? a_addr : '0;
      wdata_a_o    <= we_a_d ? a_data : '0;
      we_b_o       <= we_b_d;
      waddr_b_o    <= we_b_d ? b_addr : '0;
      wdata_b_o    <= we_b_d ? b_data : '0;
      superseded_o <= collision;
    end
  end

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Self-checking bench for cv32e40p_rf_wb_arbiter: the tasks queue the expected write-port results.
// A monitor compares those results one cycle later.
module tb_cv32e40p_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid_i = 1'b0;
  logic [5:0]  lsu_addr_i = '0;
  logic [31:0] lsu_data_i = '0;
  logic        ex_valid_i = 1'b0;
  logic [5:0]  ex_addr_i = '0;
  logic [31:0] ex_data_i = '0;
  logic        ex_ready_o;
  logic        apu_valid_i = 1'b0;
  logic [5:0]  apu_addr_i = '0;
  logic [31:0] apu_data_i = '0;
  logic        apu_ready_o;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;
  logic        we_a_o, we_b_o, superseded_o;
  logic [1:0]  apu_fifo_cnt_o;

  cv32e40p_rf_wb_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .APU_FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_data_i     (lsu_data_i),
    .ex_valid_i     (ex_valid_i),
    .ex_addr_i      (ex_addr_i),
    .ex_data_i      (ex_data_i),
    .ex_ready_o     (ex_ready_o),
    .apu_valid_i    (apu_valid_i),
    .apu_addr_i     (apu_addr_i),
    .apu_data_i     (apu_data_i),
    .apu_ready_o    (apu_ready_o),
    .waddr_a_o      (waddr_a_o),
    .wdata_a_o      (wdata_a_o),
    .we_a_o         (we_a_o),
    .waddr_b_o      (waddr_b_o),
    .wdata_b_o      (wdata_b_o),
    .we_b_o         (we_b_o),
    .superseded_o   (superseded_o),
    .apu_fifo_cnt_o (apu_fifo_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we_a;
    logic [5:0]  waddr_a;
    logic [31:0] wdata_a;
    logic        we_b;
    logic [5:0]  waddr_b;
    logic [31:0] wdata_b;
    logic        sup;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t mk(input logic wa, input logic [5:0] aa, input logic [31:0] da,
                              input logic wb, input logic [5:0] ab, input logic [31:0] db,
                              input logic s);
    exp_t e;
    e.we_a = wa; e.waddr_a = aa; e.wdata_a = da;
    e.we_b = wb; e.waddr_b = ab; e.wdata_b = db;
    e.sup  = s;
    return e;
  endfunction

  function automatic exp_t idle();
    return mk(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0);
  endfunction

  // Scoreboard monitor: one expectation per clocked cycle, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++; if (we_a_o !== mon_e.we_a) $display("FAIL sb_we_a t=%0t got=%0b exp=%0b", $time, we_a_o, mon_e.we_a); else n_pass++;
      n_checks++; if (waddr_a_o !== mon_e.waddr_a) $display("FAIL sb_waddr_a t=%0t got=%0d exp=%0d", $time, waddr_a_o, mon_e.waddr_a); else n_pass++;
      n_checks++; if (wdata_a_o !== mon_e.wdata_a) $display("FAIL sb_wdata_a t=%0t got=%h exp=%h", $time, wdata_a_o, mon_e.wdata_a); else n_pass++;
      n_checks++; if (we_b_o !== mon_e.we_b) $display("FAIL sb_we_b t=%0t got=%0b exp=%0b", $time, we_b_o, mon_e.we_b); else n_pass++;
      n_checks++; if (waddr_b_o !== mon_e.waddr_b) $display("FAIL sb_waddr_b t=%0t got=%0d exp=%0d", $time, waddr_b_o, mon_e.waddr_b); else n_pass++;
      n_checks++; if (wdata_b_o !== mon_e.wdata_b) $display("FAIL sb_wdata_b t=%0t got=%h exp=%h", $time, wdata_b_o, mon_e.wdata_b); else n_pass++;
      n_checks++; if (superseded_o !== mon_e.sup) $display("FAIL sb_superseded t=%0t got=%0b exp=%0b", $time, superseded_o, mon_e.sup); else n_pass++;
    end
  end

  task automatic drive(input logic lv, input logic [5:0] la, input logic [31:0] ld,
                       input logic ev, input logic [5:0] ea, input logic [31:0] ed,
                       input logic pv, input logic [5:0] pa, input logic [31:0] pd);
    lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
    ex_valid_i  = ev; ex_addr_i  = ea; ex_data_i  = ed;
    apu_valid_i = pv; apu_addr_i = pa; apu_data_i = pd;
  endtask

  task automatic quiet();
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic tick(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd1, 32'h1, 1'b0, 6'd0, 32'd0);
    #12;
    n_checks++; if ({we_a_o, we_b_o, superseded_o} !== 3'b000) $display("FAIL reset_we got=%b exp=000", {we_a_o, we_b_o, superseded_o}); else n_pass++;
    n_checks++; if ({waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o} !== '0) $display("FAIL reset_addr_data got=%h exp=0", {waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o}); else n_pass++;
    n_checks++; if (apu_fifo_cnt_o !== 2'd0) $display("FAIL reset_cnt got=%0d exp=0", apu_fifo_cnt_o); else n_pass++;
    n_checks++; if (apu_ready_o !== 1'b1) $display("FAIL reset_apu_ready got=%0b exp=1", apu_ready_o); else n_pass++;
    n_checks++; if (ex_ready_o !== 1'b1) $display("FAIL reset_ex_ready_comb got=%0b exp=1", ex_ready_o); else n_pass++;
    quiet();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_ex();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0);
    #1;
    n_checks++; if (ex_ready_o !== 1'b1) $display("FAIL single_ex_ready got=%0b exp=1", ex_ready_o); else n_pass++;
    tick(mk(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0));
    quiet();
    tick(idle());
  endtask

  task automatic test_round_robin();
    logic        exp_exr [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int          exp_cnt [5] = '{0, 1, 2, 1, 2};
    logic [5:0]  exp_ba  [5] = '{6'd4, 6'd4, 6'd6, 6'd4, 6'd6};
    logic [31:0] exp_bd  [5] = '{32'hE000_0000, 32'hE000_0001, 32'hA000_0000, 32'hE000_0002, 32'hA000_0001};
    int e_idx = 0;
    int a_idx = 0;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (apu_fifo_cnt_o !== 2'(exp_cnt[c])) $display("FAIL rr_cnt c=%0d got=%0d exp=%0d", c, apu_fifo_cnt_o, exp_cnt[c]); else n_pass++;
      n_checks++; if (apu_ready_o !== (exp_cnt[c] != 2)) $display("FAIL rr_apu_ready c=%0d got=%0b exp=%0b", c, apu_ready_o, exp_cnt[c] != 2); else n_pass++;
      drive(1'b1, 6'd3, 32'h1000_0000 + 32'(c),
            1'b1, 6'd4, 32'hE000_0000 + 32'(e_idx),
            1'b1, 6'd6, 32'hA000_0000 + 32'(a_idx));
      #1;
      n_checks++; if (ex_ready_o !== exp_exr[c]) $display("FAIL rr_ex_ready c=%0d got=%0b exp=%0b", c, ex_ready_o, exp_exr[c]); else n_pass++;
      if (exp_exr[c]) e_idx++;
      if (exp_cnt[c] != 2) a_idx++;
      tick(mk(1'b1, 6'd3, 32'h1000_0000 + 32'(c), 1'b1, exp_ba[c], exp_bd[c], 1'b0));
    end
    quiet();
    n_checks++; if (apu_fifo_cnt_o !== 2'd1) $display("FAIL rr_drain_cnt got=%0d exp=1", apu_fifo_cnt_o); else n_pass++;
    tick(mk(1'b1, 6'd6, 32'hA000_0002, 1'b0, 6'd0, 32'd0, 1'b0));
    n_checks++; if (apu_fifo_cnt_o !== 2'd0) $display("FAIL rr_empty_cnt got=%0d exp=0", apu_fifo_cnt_o); else n_pass++;
  endtask

  task automatic test_x0_filter();
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd0, 32'h1234, 1'b0, 6'd0, 32'd0);
    #1;
    n_checks++; if (ex_ready_o !== 1'b1) $display("FAIL x0_ex_ready got=%0b exp=1", ex_ready_o); else n_pass++;
    tick(idle());
    drive(1'b1, 6'd32, 32'h0F0F_0F0F, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    tick(mk(1'b1, 6'd32, 32'h0F0F_0F0F, 1'b0, 6'd0, 32'd0, 1'b0));
    quiet();
  endtask

  task automatic test_collision();
    drive(1'b1, 6'd7, 32'd1, 1'b1, 6'd7, 32'd2, 1'b0, 6'd0, 32'd0);
    #1;
    n_checks++; if (ex_ready_o !== 1'b1) $display("FAIL coll_ex_ready got=%0b exp=1", ex_ready_o); else n_pass++;
    tick(mk(1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 32'd2, 1'b1));
    // LSU against APU head: LSU wins
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd9, 32'hA);
    tick(idle());
    drive(1'b1, 6'd9, 32'hB, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    tick(mk(1'b0, 6'd0, 32'd0, 1'b1, 6'd9, 32'hB, 1'b1));
    n_checks++; if (apu_fifo_cnt_o !== 2'd0) $display("FAIL coll_lsu_apu_pop got=%0d exp=0", apu_fifo_cnt_o); else n_pass++;
    // EX against APU head without LSU: EX wins
    drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd10, 32'hC);
    tick(idle());
    drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd10, 32'hD, 1'b0, 6'd0, 32'd0);
    #1;
    n_checks++; if (ex_ready_o !== 1'b1) $display("FAIL coll_ex_apu_ready got=%0b exp=1", ex_ready_o); else n_pass++;
    tick(mk(1'b0, 6'd0, 32'd0, 1'b1, 6'd10, 32'hD, 1'b1));
    quiet();
    tick(idle());
  endtask

  task automatic test_apu_stream();
    int exp_cnt [5] = '{0, 1, 1, 1, 1};
    for (int s = 0; s < 5; s++) begin
      n_checks++; if (apu_fifo_cnt_o !== 2'(exp_cnt[s])) $display("FAIL stream_cnt s=%0d got=%0d exp=%0d", s, apu_fifo_cnt_o, exp_cnt[s]); else n_pass++;
      drive(1'b0, 6'd0, 32'd0,
            (s == 2), 6'd12, 32'h77,
            (s < 4), 6'(40 + s), 32'h5000 + 32'(s));
      if (s == 0)      tick(idle());
      else if (s == 2) tick(mk(1'b1, 6'd41, 32'h5001, 1'b1, 6'd12, 32'h77, 1'b0));
      else             tick(mk(1'b1, 6'(39 + s), 32'h5000 + 32'(s - 1), 1'b0, 6'd0, 32'd0, 1'b0));
    end
    quiet();
    n_checks++; if (apu_fifo_cnt_o !== 2'd0) $display("FAIL stream_end_cnt got=%0d exp=0", apu_fifo_cnt_o); else n_pass++;
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 6'd11, 32'h11, 1'b0, 6'd0, 32'd0, 1'b1, 6'd13, 32'h33);
    tick(mk(1'b1, 6'd11, 32'h11, 1'b0, 6'd0, 32'd0, 1'b0));
    drive(1'b1, 6'd11, 32'h12, 1'b1, 6'd14, 32'h44, 1'b1, 6'd15, 32'h55);
    tick(mk(1'b1, 6'd11, 32'h12, 1'b1, 6'd14, 32'h44, 1'b0));
    quiet();
    n_checks++; if (apu_fifo_cnt_o !== 2'd2) $display("FAIL midrst_pre_cnt got=%0d exp=2", apu_fifo_cnt_o); else n_pass++;
    n_checks++; if (apu_ready_o !== 1'b0) $display("FAIL midrst_pre_ready got=%0b exp=0", apu_ready_o); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({we_a_o, we_b_o, superseded_o} !== 3'b000) $display("FAIL midrst_we got=%b exp=000", {we_a_o, we_b_o, superseded_o}); else n_pass++;
    n_checks++; if ({waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o} !== '0) $display("FAIL midrst_addr_data got=%h exp=0", {waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o}); else n_pass++;
    n_checks++; if (apu_fifo_cnt_o !== 2'd0) $display("FAIL midrst_cnt got=%0d exp=0", apu_fifo_cnt_o); else n_pass++;
    n_checks++; if (apu_ready_o !== 1'b1) $display("FAIL midrst_ready got=%0b exp=1", apu_ready_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(idle());
    tick(idle());
    n_checks++; if (apu_fifo_cnt_o !== 2'd0) $display("FAIL postrst_cnt got=%0d exp=0", apu_fifo_cnt_o); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_ex();
    test_round_robin();
    test_x0_filter();
    test_collision();
    test_apu_stream();
    test_reset_midop();
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_left entries=%0d exp=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_rf_wb_arbiter.md
# cv32e40p_rf_wb_arbiter

Write-back arbiter that shares the two register-file write ports (A and B) between three result producers: load/store unit (LSU), execute stage (EX) and the auxiliary processing unit (APU). The LSU is never stalled. EX and the buffered APU results compete for the remaining port under round-robin. Same-cycle writes to one register are resolved deterministically. All write-port outputs are registered and feed the register file directly.

## Interface
- ADDR_WIDTH, 6, register address width; bit 5 selects the FP bank, addresses 0–31 are integer.
- DATA_WIDTH, 32, write data width.
- APU_FIFO_DEPTH, 2, APU result buffer entries; power of two, ≥2.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low (rst_n); clock clk
- lsu_valid_i  in  1  LSU result valid; no ready, always accepted
- lsu_addr_i  in  ADDR_WIDTH  LSU destination register
- lsu_data_i  in  DATA_WIDTH  LSU result
- ex_valid_i  in  1  EX result valid
- ex_addr_i  in  ADDR_WIDTH  EX destination register
- ex_data_i  in  DATA_WIDTH  EX result
- ex_ready_o  out  1  EX result accepted this cycle (combinational)
- apu_valid_i  in  1  APU result valid
- apu_addr_i  in  ADDR_WIDTH  APU destination register
- apu_data_i  in  DATA_WIDTH  APU result
- apu_ready_o  out  1  APU FIFO not full (from registered state)
- waddr_a_o, wdata_a_o, we_a_o  out  ADDR_WIDTH/DATA_WIDTH/1  register-file write port A
- waddr_b_o, wdata_b_o, we_b_o  out  ADDR_WIDTH/DATA_WIDTH/1  register-file write port B; the register file lets B win over A on equal addresses
- superseded_o  out  1  one-cycle pulse: an accepted write was dropped due to a same-address collision
- apu_fifo_cnt_o  out  $clog2(APU_FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- APU path: accept when apu_valid_i && apu_ready_o; push into FIFO. The head entry is a write candidate from the cycle after the push. There is no bypass.
- Candidates each cycle: L = lsu_valid_i; E = ex_valid_i; P = FIFO non-empty.
- Grant:
  - L is always granted.
  - If L is absent, E and P are both granted.
  - If L is present with E and P, only one of E/P is granted, chosen by rr.
  - If L is present with only one of E/P, that one is granted.
- rr (1 flop, reset 0): 0 favours EX, 1 favours APU.
  - Updates only on a three-way contention: EX granted → rr=1; APU granted → rr=0.
- ex_ready_o = E granted. The FIFO pops when P is granted.
- Port mapping of granted writes:
  - LSU → A.
  - Other granted one → B.
  - Without LSU: APU → A, EX → B.
- x0 filter: a granted write with addr==0 is consumed (ready/pop) but its we stays 0. Address 32 (FP f0) is a normal register.
- Collision: two granted writes to the same nonzero address.
  - Priority is EX > LSU > APU.
  - The winner is placed on port B; the loser is consumed, not written, and superseded_o=1.
- FIFO:
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - Enqueue while full is impossible because ready is low.
  - Pointers wrap modulo APU_FIFO_DEPTH.

## Timing
- Write latency: grant in cycle N → we_*_o/waddr/wdata valid in cycle N+1 for exactly one cycle.
- APU minimum latency: accept N → FIFO head N+1 → port output N+2.
- superseded_o is registered and aligned with the write outputs of the same grant (N+1).
- When we is 0, waddr/wdata hold 0.
- Reset values:
  - all we_*_o, waddr_*_o, wdata_*_o, superseded_o = 0
  - apu_fifo_cnt_o = 0, apu_ready_o = 1, rr = 0
  - ex_ready_o follows its combinational equation.
- Reset asserted mid-operation: FIFO contents and pending output writes are discarded immediately (asynchronous). Producers must re-issue.
- apu_ready_o does not depend on the same-cycle pop, so a full FIFO accepts again one cycle after the pop.

## Test plan
- Single EX write, addr 5, data 0xDEADBEEF → next cycle we_b_o=1, waddr_b_o=5, wdata_b_o=0xDEADBEEF; we_a_o=0.
- LSU addr 3 + EX addr 4 + FIFO head addr 6 for 4 cycles from reset → EX granted in cycles 0 and 2, APU in cycles 1 and 3; LSU written on port A every cycle.
- EX addr 0 alone → ex_ready_o=1, no write next cycle; LSU addr 32 → we_a_o=1, waddr_a_o=32.
- LSU addr 7 data 1 + EX addr 7 data 2 → port B writes addr 7 data 2, we_a_o=0, superseded_o=1.
- APU valid continuously, no other traffic:
  - apu_fifo_cnt_o steps 0→1, then holds at 1 (push and pop each cycle).
  - With LSU and EX also continuously valid, the count reaches 2, apu_ready_o drops, and it recovers after the next APU grant.
- Assert rst_n low with FIFO count 2 and a write pending → all outputs 0 immediately, count 0, apu_ready_o=1; after release, no stale write appears.
